// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front-end: widths, FSM states and the
// {pc, insn} entry carried through the fetch FIFO.
package fetch_pkg;

  localparam int ADDR_W = 8;
  localparam int INSN_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FULL
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSN_W-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush and a registered head entry, so
// the consumer never sees a combinational path from the write data.
module fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  fetch_pkg::fetch_entry_t       push_entry,
  input  logic                          pop,
  input  logic                          flush,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          head_valid,
  output fetch_pkg::fetch_entry_t       head
);
  import fetch_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t    store [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_next;
  logic [CW-1:0]   count_next;
  logic [CW-1:0]   after_pop;
  logic            pop_ok;
  logic            push_ok;

  always_comb begin
    pop_ok     = pop && !flush && (count != '0);
    push_ok    = push && !flush && ((count != DEPTH_C) || pop_ok);
    after_pop  = count - CW'(pop_ok);
    count_next = after_pop + CW'(push_ok);
    rd_next    = rd_ptr + PW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      store[wr_ptr] <= push_entry;
    end
  end

  // The head register holds its last value whenever the FIFO goes empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_next;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      count <= count_next;
      if (count_next != '0) begin
        // The new entry becomes head when nothing older survives the pop.
        head <= (after_pop == '0) ? push_entry : store[rd_next];
      end
    end
  end

  assign head_valid = (count != '0);

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front-end: issues 16-bit reads with credit-based flow control, tags
// responses with their PC and queues them for the decode stage; handles redirects.
module instr_fetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 8,
  parameter int                INSN_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [INSN_W-1:0] mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              insn_valid,
  output logic [INSN_W-1:0] insn_data,
  output logic [ADDR_W-1:0] insn_pc,
  input  logic              insn_ready
);
  import fetch_pkg::*;

  // Handshakes: a transfer happens in a cycle where valid/req and ready/gnt are
  // both high; req/valid never depend combinationally on ready/gnt.
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     DEPTH_C  = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ALIGN_M  = ~ADDR_W'(1);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] tag_pc;
  logic            inflight;
  logic            discard;
  logic            accept;
  logic            push;
  logic            push_eff;
  logic            pop_eff;
  logic            credit_ok;
  logic [CW-1:0]   count;
  logic [CW-1:0]   occ_next;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  always_comb begin
    credit_ok = (count + CW'(inflight)) < DEPTH_C;
    push      = inflight && !discard;
    push_eff  = push && !redirect_valid;
    pop_eff   = insn_valid && insn_ready && !redirect_valid;
  end

  // Occupancy after this edge, counting the request accepted this cycle.
  assign occ_next = redirect_valid ? '0
                  : count + CW'(push_eff) - CW'(pop_eff) + CW'(accept);

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        mem_req = credit_ok && !redirect_valid;
        if (occ_next >= DEPTH_C) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (occ_next < DEPTH_C) begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (redirect_valid) begin
      state_next = FETCH;
    end
  end

  assign accept   = mem_req && mem_gnt;
  assign mem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC & ALIGN_M;
      tag_pc   <= '0;
      inflight <= 1'b0;
      discard  <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= accept;
      discard  <= redirect_valid && inflight;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ALIGN_M;
      end else if (accept) begin
        fetch_pc <= fetch_pc + PC_STEP;
        tag_pc   <= fetch_pc;
      end
    end
  end

  assign push_entry = '{pc: tag_pc, insn: mem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (insn_ready),
    .flush      (redirect_valid),
    .count      (count),
    .head_valid (insn_valid),
    .head       (head)
  );

  assign insn_data = head.insn;
  assign insn_pc   = head.pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: a cycle table covering power-up, redirects and
// PC wrap, plus sequences for back-pressure, grant stall and mid-run reset.
module tb_instr_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_gnt;
  logic [15:0] mem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        insn_valid;
  logic [15:0] insn_data;
  logic [7:0]  insn_pc;
  logic        insn_ready;

  int total;
  int bad;

  logic [15:0] mem_model [128];
  logic [23:0] exp_q [$];

  typedef struct {
    logic        rst_n;
    logic        gnt;
    logic        ready;
    logic        rv;
    logic [7:0]  rpc;
    logic        req;
    logic [7:0]  addr;
    logic        valid;
    logic [7:0]  pc;
    logic [15:0] data;
  } vec_t;

  vec_t vecs [25];

  instr_fetch_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .insn_valid     (insn_valid),
    .insn_data      (insn_data),
    .insn_pc        (insn_pc),
    .insn_ready     (insn_ready)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous 128x16 memory; poison data when no read was accepted.
  always @(posedge clk) begin
    if (mem_req && mem_gnt) mem_rdata <= mem_model[mem_addr[7:1]];
    else                    mem_rdata <= 16'hDEAD;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mkv(input logic r, input logic g, input logic rdy,
                               input logic rv, input logic [7:0] rpc,
                               input logic req, input logic [7:0] addr,
                               input logic v, input logic [7:0] pc,
                               input logic [15:0] d);
    vec_t t;
    t.rst_n = r;  t.gnt = g;    t.ready = rdy; t.rv = rv; t.rpc = rpc;
    t.req = req;  t.addr = addr; t.valid = v;  t.pc = pc; t.data = d;
    return t;
  endfunction

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 128; i++) mem_model[i] = 16'hA000 + 16'(i);
    mem_model[0] = 16'hF10A;
    mem_model[1] = 16'hF202;
    mem_model[2] = 16'hC307;

    //              rst g  rdy rv rpc   | req addr  v  pc     data
    vecs[0]  = mkv(0, 1, 1, 0, 8'h00,   0, 8'h00, 0, 8'h00, 16'h0000);
    vecs[1]  = mkv(1, 1, 1, 0, 8'h00,   0, 8'h00, 0, 8'h00, 16'h0000);
    vecs[2]  = mkv(1, 1, 1, 0, 8'h00,   1, 8'h00, 0, 8'h00, 16'h0000);
    vecs[3]  = mkv(1, 1, 1, 0, 8'h00,   1, 8'h02, 0, 8'h00, 16'h0000);
    vecs[4]  = mkv(1, 1, 1, 0, 8'h00,   1, 8'h04, 1, 8'h00, 16'hF10A);
    vecs[5]  = mkv(1, 1, 1, 0, 8'h00,   1, 8'h06, 1, 8'h02, 16'hF202);
    vecs[6]  = mkv(1, 1, 1, 0, 8'h00,   1, 8'h08, 1, 8'h04, 16'hC307);
    vecs[7]  = mkv(1, 1, 1, 0, 8'h00,   1, 8'h0A, 1, 8'h06, 16'hA003);
    vecs[8]  = mkv(1, 1, 1, 1, 8'h41,   0, 8'h0C, 1, 8'h08, 16'hA004);
    vecs[9]  = mkv(1, 1, 1, 0, 8'h00,   1, 8'h40, 0, 8'h08, 16'hA004);
    vecs[10] = mkv(1, 1, 1, 0, 8'h00,   1, 8'h42, 0, 8'h08, 16'hA004);
    vecs[11] = mkv(1, 1, 1, 0, 8'h00,   1, 8'h44, 1, 8'h40, 16'hA020);
    vecs[12] = mkv(1, 1, 1, 0, 8'h00,   1, 8'h46, 1, 8'h42, 16'hA021);
    vecs[13] = mkv(1, 1, 1, 1, 8'hFC,   0, 8'h48, 1, 8'h44, 16'hA022);
    vecs[14] = mkv(1, 1, 1, 0, 8'h00,   1, 8'hFC, 0, 8'h44, 16'hA022);
    vecs[15] = mkv(1, 1, 1, 0, 8'h00,   1, 8'hFE, 0, 8'h44, 16'hA022);
    vecs[16] = mkv(1, 1, 1, 0, 8'h00,   1, 8'h00, 1, 8'hFC, 16'hA07E);
    vecs[17] = mkv(1, 1, 1, 0, 8'h00,   1, 8'h02, 1, 8'hFE, 16'hA07F);
    vecs[18] = mkv(1, 1, 1, 0, 8'h00,   1, 8'h04, 1, 8'h00, 16'hF10A);
    vecs[19] = mkv(1, 1, 1, 0, 8'h00,   1, 8'h06, 1, 8'h02, 16'hF202);
    vecs[20] = mkv(1, 1, 1, 1, 8'h20,   0, 8'h08, 1, 8'h04, 16'hC307);
    vecs[21] = mkv(1, 1, 1, 1, 8'h30,   0, 8'h20, 0, 8'h04, 16'hC307);
    vecs[22] = mkv(1, 1, 1, 0, 8'h00,   1, 8'h30, 0, 8'h04, 16'hC307);
    vecs[23] = mkv(1, 1, 1, 0, 8'h00,   1, 8'h32, 0, 8'h04, 16'hC307);
    vecs[24] = mkv(1, 1, 1, 0, 8'h00,   1, 8'h34, 1, 8'h30, 16'hA018);

    rst_n = 1'b0;
    mem_gnt = 1'b0;
    insn_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    repeat (2) @(posedge clk);

    // Table: drive at negedge, check 1 time unit later, edge follows.
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n;
      mem_gnt = vecs[i].gnt;
      insn_ready = vecs[i].ready;
      redirect_valid = vecs[i].rv;
      redirect_pc = vecs[i].rpc;
      #1;
      chk($sformatf("row%0d mem_req", i),    32'(mem_req),    32'(vecs[i].req));
      chk($sformatf("row%0d mem_addr", i),   32'(mem_addr),   32'(vecs[i].addr));
      chk($sformatf("row%0d insn_valid", i), 32'(insn_valid), 32'(vecs[i].valid));
      chk($sformatf("row%0d insn_pc", i),    32'(insn_pc),    32'(vecs[i].pc));
      chk($sformatf("row%0d insn_data", i),  32'(insn_data),  32'(vecs[i].data));
    end

    // Back-pressure: exactly four grants, then drain in order without gaps.
    begin
      int grants;
      insn_ready = 1'b0;
      mem_gnt = 1'b1;
      do_reset();
      grants = 0;
      repeat (10) begin
        @(negedge clk);
        #1;
        if (mem_req) begin
          chk("bp grant addr", 32'(mem_addr), 32'(grants * 2));
          grants++;
        end
      end
      chk("bp grant count", 32'(grants), 32'd4);
      chk("bp req when full", 32'(mem_req), 32'd0);
      chk("bp head valid", 32'(insn_valid), 32'd1);
      for (int k = 0; k < 8; k++) exp_q.push_back({8'(k * 2), mem_model[k]});
      for (int k = 0; k < 8; k++) begin
        logic [23:0] e;
        @(negedge clk);
        insn_ready = 1'b1;
        #1;
        e = exp_q.pop_front();
        chk($sformatf("bp pop%0d valid", k), 32'(insn_valid), 32'd1);
        chk($sformatf("bp pop%0d entry", k), {8'h00, insn_pc, insn_data}, {8'h00, e});
      end
    end

    // Grant stall: address holds while gnt=0, single entry after one grant.
    insn_ready = 1'b0;
    mem_gnt = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("stall%0d req", k), 32'(mem_req), 32'd1);
      chk($sformatf("stall%0d addr", k), 32'(mem_addr), 32'h00);
    end
    @(negedge clk);
    mem_gnt = 1'b1;
    #1;
    chk("stall grant addr", 32'(mem_addr), 32'h00);
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    chk("stall next addr", 32'(mem_addr), 32'h02);
    chk("stall valid early", 32'(insn_valid), 32'd0);
    @(negedge clk);
    insn_ready = 1'b1;
    #1;
    chk("stall head valid", 32'(insn_valid), 32'd1);
    chk("stall head entry", {8'h00, insn_pc, insn_data}, {16'h0000, 16'hF10A});
    @(negedge clk);
    insn_ready = 1'b0;
    #1;
    chk("stall no duplicate", 32'(insn_valid), 32'd0);
    chk("stall addr held", 32'(mem_addr), 32'h02);

    // Reset while entries are queued and a read is outstanding.
    mem_gnt = 1'b1;
    insn_ready = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst insn_valid", 32'(insn_valid), 32'd0);
    chk("mrst mem_req", 32'(mem_req), 32'd0);
    chk("mrst mem_addr", 32'(mem_addr), 32'h00);
    chk("mrst head", {8'h00, insn_pc, insn_data}, 32'h0);
    @(negedge clk);
    insn_ready = 1'b1;
    #1;
    chk("mrst restart req", 32'(mem_req), 32'd1);
    chk("mrst restart addr", 32'(mem_addr), 32'h00);
    begin
      int waited;
      waited = 0;
      while (!insn_valid && waited < 10) begin
        @(negedge clk);
        #1;
        waited++;
      end
      chk("mrst first valid in time", 32'(insn_valid), 32'd1);
      chk("mrst first entry", {8'h00, insn_pc, insn_data}, {16'h0000, 16'hF10A});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
